// File: rtl/ctrl_vdma_in_pkg.sv
// ctrl_vdma_in_pkg: shared types and constants for the VDMA S2MM input controller.
// Optional build macro used by ctrl_vdma_in: CTRL_VDMA_IN_STATS_EN.
package ctrl_vdma_in_pkg;

    // Default pixel beat width and the FIFO word layout {tlast, tuser, data}
    localparam int DATA_W_DEF = 64;
    localparam int FIFO_W     = DATA_W_DEF + 2;
    localparam int TUSER_BIT  = DATA_W_DEF;
    localparam int TLAST_BIT  = DATA_W_DEF + 1;

    // Column/row counter width; geometry arithmetic uses CNT_W+1 bits
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

endpackage

// File: rtl/ctrl_vdma_in_if.sv
// ctrl_vdma_in_if: AXI4-Stream video bus between the controller and the VDMA S2MM port.
// Handshake: a beat transfers on a clock edge where tvalid && tready are both high;
// once tvalid is raised, tdata/tuser/tlast stay stable and tvalid stays high until
// that transfer happens. tready may change freely.
interface ctrl_vdma_in_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/ctrl_vdma_in_fifo.sv
// ctrl_vdma_in_fifo: synchronous first-word-fall-through FIFO. The head word is
// presented combinationally from the storage array whenever the FIFO is not empty,
// so a word written at an edge is readable in the following cycle.
module ctrl_vdma_in_fifo #(
    parameter int FIFO_DEPTH = 1024,
    parameter int WIDTH      = 66
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head word is forced to zero while empty so the bus idles at all-zero
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the FIFO
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers qualify them
    always_ff @(posedge s_axis_aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ctrl_vdma_in.sv
// ctrl_vdma_in: video-to-VDMA S2MM input controller. Frames a non-backpressurable
// pixel stream into AXI4-Stream video (tuser = start of frame, tlast = end of line)
// through a FWFT FIFO; on FIFO overflow the rest of the frame is dropped.
// Optional macro CTRL_VDMA_IN_STATS_EN adds frame_cnt / drop_cnt statistics ports.
module ctrl_vdma_in
    import ctrl_vdma_in_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    input  logic               enable,
    input  logic [31:0]        vdma_column,
    input  logic [31:0]        vdma_row,
    input  logic               vid_fsync,
    input  logic               vid_valid,
    input  logic [DATA_W-1:0]  vid_data,
    ctrl_vdma_in_if.master     m_axis_s2mm,
    output logic               overflow,
    output logic               short_frame,
    output logic               frame_done,
    input  logic               clear,
`ifdef CTRL_VDMA_IN_STATS_EN
    output logic [31:0]        frame_cnt,
    output logic [31:0]        drop_cnt,
`endif
    output state_t             dbg_state
);
    localparam int FW = DATA_W + 2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0] cmax_q, cmax_d, rmax_q, rmax_d;
    logic             ovf_d, short_d;
    logic             eff_active, eff_drop;
    logic             short_set, ovf_set, done_set, drop_inc;
    logic             wr_en, wr_user, wr_last;
    logic             fifo_full, fifo_empty;
    logic [FW-1:0]    fifo_rd_data;
    logic             unused_geom;

    assign unused_geom = ^{vdma_column[31:CNT_W], vdma_row[31:CNT_W]};
    assign dbg_state   = state_q;

    // FSM and counter registers, sticky flags and the frame_done pulse
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            cmax_q      <= '0;
            rmax_q      <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cmax_q      <= cmax_d;
            rmax_q      <= rmax_d;
            overflow    <= ovf_d;
            short_frame <= short_d;
            frame_done  <= done_set;
        end
    end

    // Next state: fsync is applied first, then a same-cycle beat is handled in the new frame
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        cmax_d     = cmax_q;
        rmax_d     = rmax_q;
        eff_active = (state_q == ST_ACTIVE);
        eff_drop   = (state_q == ST_DROP);
        short_set  = 1'b0;
        ovf_set    = 1'b0;
        done_set   = 1'b0;
        drop_inc   = 1'b0;
        wr_en      = 1'b0;
        wr_user    = 1'b0;
        wr_last    = 1'b0;

        if (vid_fsync) begin
            short_set = (state_q == ST_ACTIVE);
            col_d     = '0;
            row_d     = '0;
            cmax_d    = vdma_column[CNT_W-1:0];
            rmax_d    = vdma_row[CNT_W-1:0];
            if (enable && (vdma_column[CNT_W-1:0] != '0) && (vdma_row[CNT_W-1:0] != '0)) begin
                state_d = ST_ACTIVE;
            end else begin
                state_d = ST_IDLE;
            end
            eff_active = (state_d == ST_ACTIVE);
            eff_drop   = 1'b0;
        end

        if (vid_valid && eff_active) begin
            if (fifo_full) begin
                // Full flag is the registered one, before any same-cycle pop
                ovf_set  = 1'b1;
                drop_inc = 1'b1;
                state_d  = ST_DROP;
            end else begin
                wr_en   = 1'b1;
                wr_user = (col_d == '0) && (row_d == '0);
                wr_last = ({1'b0, col_d} == ({1'b0, cmax_d} - (CNT_W+1)'(1)));
                if (wr_last) begin
                    col_d = '0;
                    if ({1'b0, row_d} == ({1'b0, rmax_d} - (CNT_W+1)'(1))) begin
                        row_d    = '0;
                        done_set = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        row_d = row_d + CNT_W'(1);
                    end
                end else begin
                    col_d = col_d + CNT_W'(1);
                end
            end
        end else if (vid_valid && eff_drop) begin
            drop_inc = 1'b1;
        end

        // Set wins over a same-cycle clear
        ovf_d   = ovf_set   | (overflow    & ~clear);
        short_d = short_set | (short_frame & ~clear);
    end

`ifdef CTRL_VDMA_IN_STATS_EN
    // Saturating statistics counters
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (done_set && (frame_cnt != '1)) frame_cnt <= frame_cnt + 32'd1;
            if (drop_inc && (drop_cnt  != '1)) drop_cnt  <= drop_cnt  + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = drop_inc;
`endif

    ctrl_vdma_in_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (FW)
    ) u_fifo (
        .s_axis_aclk    (s_axis_aclk),
        .s_axis_aresetn (s_axis_aresetn),
        .wr_en          (wr_en),
        .wr_data        ({wr_last, wr_user, vid_data}),
        .rd_en          (m_axis_s2mm.tready),
        .rd_data        (fifo_rd_data),
        .full           (fifo_full),
        .empty          (fifo_empty)
    );

    assign m_axis_s2mm.tvalid = !fifo_empty;
    assign m_axis_s2mm.tdata  = fifo_rd_data[DATA_W-1:0];
    assign m_axis_s2mm.tuser  = fifo_rd_data[DATA_W];
    assign m_axis_s2mm.tlast  = fifo_rd_data[DATA_W+1];

endmodule

// File: tb/tb_ctrl_vdma_in.sv
// tb_ctrl_vdma_in: self-checking bench for ctrl_vdma_in (FIFO_DEPTH=16).
module tb_ctrl_vdma_in;
    import ctrl_vdma_in_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic          s_axis_aclk = 1'b0;
    logic          s_axis_aresetn = 1'b0;
    logic          enable = 1'b0;
    logic [31:0]   vdma_column = '0;
    logic [31:0]   vdma_row = '0;
    logic          vid_fsync = 1'b0;
    logic          vid_valid = 1'b0;
    logic [DW-1:0] vid_data = '0;
    logic          clear = 1'b0;
    logic          overflow, short_frame, frame_done;
    state_t        dbg_state;
`ifdef CTRL_VDMA_IN_STATS_EN
    logic [31:0]   frame_cnt, drop_cnt;
`endif

    ctrl_vdma_in_if #(.DATA_W(DW)) m_axis_s2mm ();

    ctrl_vdma_in #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .s_axis_aclk    (s_axis_aclk),
        .s_axis_aresetn (s_axis_aresetn),
        .enable         (enable),
        .vdma_column    (vdma_column),
        .vdma_row       (vdma_row),
        .vid_fsync      (vid_fsync),
        .vid_valid      (vid_valid),
        .vid_data       (vid_data),
        .m_axis_s2mm    (m_axis_s2mm),
        .overflow       (overflow),
        .short_frame    (short_frame),
        .frame_done     (frame_done),
        .clear          (clear),
`ifdef CTRL_VDMA_IN_STATS_EN
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt),
`endif
        .dbg_state      (dbg_state)
    );

    // Clock / watchdog
    always #5 s_axis_aclk = ~s_axis_aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;    // 0: always ready, 1: toggle, 2: random, 3: never
    int fd_cnt = 0;
    int stall_viol = 0;
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] got_q[$];
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_word = '0;

    // VDMA-side ready driver
    initial m_axis_s2mm.tready = 1'b1;
    always @(posedge s_axis_aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_s2mm.tready = 1'b1;
            1:       m_axis_s2mm.tready = ~m_axis_s2mm.tready;
            2:       m_axis_s2mm.tready = 1'($urandom_range(1, 0));
            default: m_axis_s2mm.tready = 1'b0;
        endcase
    end

    // Output monitor: collects transferred beats, frame_done pulses, stall stability
    always @(negedge s_axis_aclk) begin
        logic [DW+1:0] word;
        word = {m_axis_s2mm.tlast, m_axis_s2mm.tuser, m_axis_s2mm.tdata};
        if (!s_axis_aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(m_axis_s2mm.tvalid && word == prev_word)) stall_viol++;
            if (m_axis_s2mm.tvalid && m_axis_s2mm.tready) got_q.push_back(word);
            if (frame_done) fd_cnt++;
            prev_stall = m_axis_s2mm.tvalid && !m_axis_s2mm.tready;
            prev_word  = word;
        end
    end

    // Driver: one video cycle, applied just after the rising edge
    task automatic send(input logic fs, input logic vv, input logic [DW-1:0] d);
        @(posedge s_axis_aclk);
        #1;
        vid_fsync = fs;
        vid_valid = vv;
        vid_data  = d;
    endtask

    task automatic pulse_clear();
        @(posedge s_axis_aclk);
        #1 clear = 1'b1;
        @(posedge s_axis_aclk);
        #1 clear = 1'b0;
        @(negedge s_axis_aclk);
    endtask

    // Drives one frame and records the expected output: beat i of a C x R frame
    // carries tuser when i==0 and tlast when i%C==C-1; at most cap beats fit.
    task automatic run_frame(input int cols, input int rows, input int nbeats,
                             input bit en, input int gap_pct, input int cap);
        int c, r, pushed;
        bit fs_pending;
        logic [DW-1:0] d;
        logic u, l;
        c = cols & 32'hFFFF;
        r = rows & 32'hFFFF;
        pushed = 0;
        fs_pending = 1'b1;
        vdma_column = cols;
        vdma_row = rows;
        enable = en;
        if ($urandom_range(1, 0) == 1) begin
            send(1'b1, 1'b0, '0);
            fs_pending = 1'b0;
        end
        for (int i = 0; i < nbeats; i++) begin
            for (int g = 0; g < 3 && int'($urandom_range(99, 0)) < gap_pct; g++) send(1'b0, 1'b0, '0);
            d = {$urandom, $urandom};
            send(fs_pending, 1'b1, d);
            fs_pending = 1'b0;
            if (en && c > 0 && r > 0 && i < c * r && pushed < cap) begin
                u = (i == 0);
                l = ((i % c) == c - 1);
                exp_q.push_back({l, u, d});
                pushed++;
            end
        end
        send(1'b0, 1'b0, '0);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 2000 && got_q.size() < exp_q.size(); c++) @(negedge s_axis_aclk);
        repeat (8) @(negedge s_axis_aclk);
    endtask

    task automatic start_scenario();
        exp_q.delete();
        got_q.delete();
        fd_cnt = 0;
        stall_viol = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        n_tests++; if (m_axis_s2mm.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_s2mm.tvalid); end
        n_tests++; if ({m_axis_s2mm.tlast, m_axis_s2mm.tuser, m_axis_s2mm.tdata} !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_axis_s2mm.tdata); end
        n_tests++; if ({overflow, short_frame, frame_done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {overflow, short_frame, frame_done}); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        @(posedge s_axis_aclk);
        #1 s_axis_aresetn = 1'b1;
        // Reset asserted mid-frame flushes the FIFO asynchronously
        start_scenario();
        rdy_mode = 3;
        run_frame(4, 3, 3, 1'b1, 0, DEPTH);
        @(negedge s_axis_aclk);
        n_tests++; if (m_axis_s2mm.tvalid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_tvalid: got %b want 1", m_axis_s2mm.tvalid); end
        @(posedge s_axis_aclk);
        #2 s_axis_aresetn = 1'b0;
        #1;
        n_tests++; if (m_axis_s2mm.tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_tvalid: got %b want 0", m_axis_s2mm.tvalid); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        @(posedge s_axis_aclk);
        #1 s_axis_aresetn = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge s_axis_aclk);
        n_tests++; if (m_axis_s2mm.tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_flushed: got %b want 0", m_axis_s2mm.tvalid); end
        start_scenario();
    endtask

    task automatic test_basic();
        start_scenario();
        rdy_mode = 0;
        run_frame(4, 3, 12, 1'b1, 0, DEPTH);
        wait_drain();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL basic_frame_done: got %0d pulses want 1", fd_cnt); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL basic_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_stall();
        start_scenario();
        rdy_mode = 1;
        run_frame(4, 3, 12, 1'b1, 0, DEPTH);
        wait_drain();
        rdy_mode = 0;
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_short_frame();
        logic [DW-1:0] d;
        start_scenario();
        rdy_mode = 0;
        run_frame(4, 3, 6, 1'b1, 0, DEPTH);
        @(negedge s_axis_aclk);
        n_tests++; if (short_frame !== 1'b0) begin n_fail++; $display("FAIL short_before: got %b want 0", short_frame); end
        n_tests++; if (dbg_state !== ST_ACTIVE) begin n_fail++; $display("FAIL short_midstate: got %0d want %0d", dbg_state, ST_ACTIVE); end
        // New fsync with a beat and a simultaneous clear: set wins, beat opens the new frame
        d = {$urandom, $urandom};
        @(posedge s_axis_aclk);
        #1;
        clear = 1'b1; vid_fsync = 1'b1; vid_valid = 1'b1; vid_data = d;
        exp_q.push_back({1'b0, 1'b1, d});
        for (int i = 1; i < 12; i++) begin
            d = {$urandom, $urandom};
            send(1'b0, 1'b1, d);
            clear = 1'b0;
            exp_q.push_back({((i % 4) == 3) ? 1'b1 : 1'b0, 1'b0, d});
        end
        send(1'b0, 1'b0, '0);
        wait_drain();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL short_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL short_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (short_frame !== 1'b1) begin n_fail++; $display("FAIL short_flag: got %b want 1", short_frame); end
        n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL short_frame_done: got %0d want 1", fd_cnt); end
        pulse_clear();
        n_tests++; if (short_frame !== 1'b0) begin n_fail++; $display("FAIL short_clear: got %b want 0", short_frame); end
    endtask

    task automatic test_disabled();
        start_scenario();
        rdy_mode = 0;
        run_frame(4, 3, 12, 1'b0, 10, DEPTH);
        run_frame(0, 3, 12, 1'b1, 10, DEPTH);
        run_frame(4, 0, 12, 1'b1, 10, DEPTH);
        run_frame(32'h0001_0000, 3, 12, 1'b1, 10, DEPTH);
        wait_drain();
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL disabled_beats: got %0d beats want 0", got_q.size()); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL disabled_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_tests++; if (fd_cnt != 0) begin n_fail++; $display("FAIL disabled_frame_done: got %0d want 0", fd_cnt); end
    endtask

    task automatic test_random();
        int c, r;
        start_scenario();
        run_frame(1, 2, 2, 1'b1, 0, DEPTH);
        wait_drain();
        for (int it = 0; it < 8; it++) begin
            c = int'($urandom_range(4, 1));
            r = int'($urandom_range(4, 1));
            rdy_mode = 2;
            run_frame(c, r, c * r + int'($urandom_range(2, 0)), 1'b1, 30, DEPTH);
            rdy_mode = 0;
            wait_drain();
        end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (fd_cnt != 9) begin n_fail++; $display("FAIL random_frame_done: got %0d want 9", fd_cnt); end
        n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL random_hold: got %0d unstable cycles want 0", stall_viol); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL random_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d;
        start_scenario();
        rdy_mode = 3;
        vdma_column = 32; vdma_row = 2; enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            d = {$urandom, $urandom};
            send(i == 0, 1'b1, d);
            exp_q.push_back({((i % 32) == 31) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, d});
        end
        send(1'b0, 1'b0, '0);
        @(negedge s_axis_aclk);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at16: got %b want 0", overflow); end
        n_tests++; if (dbg_state !== ST_ACTIVE) begin n_fail++; $display("FAIL ovf_state16: got %0d want %0d", dbg_state, ST_ACTIVE); end
        send(1'b0, 1'b1, {$urandom, $urandom});
        send(1'b0, 1'b0, '0);
        @(negedge s_axis_aclk);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_at17: got %b want 1", overflow); end
        n_tests++; if (dbg_state !== ST_DROP) begin n_fail++; $display("FAIL ovf_state17: got %0d want %0d", dbg_state, ST_DROP); end
        for (int i = 17; i < 64; i++) send(1'b0, 1'b1, {$urandom, $urandom});
        send(1'b0, 1'b0, '0);
        rdy_mode = 0;
        wait_drain();
        run_frame(4, 3, 12, 1'b1, 20, DEPTH);
        wait_drain();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (short_frame !== 1'b0) begin n_fail++; $display("FAIL ovf_short: got %b want 0", short_frame); end
        n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL ovf_frame_done: got %0d want 1", fd_cnt); end
        pulse_clear();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

`ifdef CTRL_VDMA_IN_STATS_EN
    task automatic test_stats();
        pulse_clear();
        start_scenario();
        rdy_mode = 0;
        run_frame(2, 2, 4, 1'b1, 20, DEPTH);
        wait_drain();
        run_frame(3, 2, 6, 1'b1, 20, DEPTH);
        wait_drain();
        rdy_mode = 3;
        run_frame(4, 9, 36, 1'b1, 20, DEPTH);
        @(negedge s_axis_aclk);
        n_tests++; if (frame_cnt !== 32'd2) begin n_fail++; $display("FAIL stats_frame_cnt: got %0d want 2", frame_cnt); end
        n_tests++; if (drop_cnt !== 32'd20) begin n_fail++; $display("FAIL stats_drop_cnt: got %0d want 20", drop_cnt); end
        rdy_mode = 0;
        wait_drain();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stats_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        pulse_clear();
        n_tests++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_frame_clr: got %0d want 0", frame_cnt); end
        n_tests++; if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_drop_clr: got %0d want 0", drop_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_short_frame();
        test_disabled();
        test_random();
        test_overflow();
`ifdef CTRL_VDMA_IN_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_vdma_in.md
# ctrl_vdma_in

Video-to-VDMA S2MM input controller. Accepts a free-running, non-backpressurable 64-bit pixel-beat stream framed by a frame-sync pulse. Counts columns and rows against the programmed frame geometry and emits AXI4-Stream video: tuser on the first beat of the frame, tlast on the last beat of every line. An internal FIFO absorbs VDMA S2MM stalls. On overflow, the remainder of the frame is dropped and the block resynchronises on the next frame sync.

## Interface
Parameters:
- FIFO_DEPTH, 1024, entries of the internal FIFO (power of two, ≥16).
- DATA_W, 64, pixel beat width.

Ports:
- s_axis_aclk  in  1  clock.
- s_axis_aresetn  in  1  reset, asynchronous, active-low.
- enable  in  1  capture enable, sampled only on vid_fsync.
- vdma_column  in  32  beats per line; only [15:0] used.
- vdma_row  in  32  lines per frame; only [15:0] used.
- vid_fsync  in  1  one-cycle frame-start pulse.
- vid_valid  in  1  pixel beat valid; no backpressure to source.
- vid_data  in  DATA_W  pixel beat.
- m_axis_s2mm_tdata  out  DATA_W  stream data.
- m_axis_s2mm_tvalid  out  1  stream valid.
- m_axis_s2mm_tready  in  1  VDMA ready.
- m_axis_s2mm_tuser  out  1  start of frame.
- m_axis_s2mm_tlast  out  1  end of line.
- overflow  out  1  sticky; beat lost because FIFO was full.
- short_frame  out  1  sticky; fsync arrived before frame completed.
- frame_done  out  1  one-cycle pulse when the last beat of a frame is written to the FIFO.
- clear  in  1  synchronous clear of sticky flags (and counters when STATS enabled).

## Operation
- State machine IDLE / ACTIVE / DROP.
  - IDLE: vid_valid ignored.
  - vid_fsync with enable=1 and nonzero geometry → ACTIVE. vdma_column[15:0] and vdma_row[15:0] are latched on this cycle.
  - vid_fsync with enable=0, or with either geometry value 0 → stay IDLE.
- ACTIVE: each vid_valid beat is written to the FIFO as {tlast, tuser, data}.
  - tuser = (col==0 && row==0).
  - tlast = (col==col_max−1).
  - col increments per beat and wraps to 0 after tlast; row increments on wrap.
  - Beat with col==col_max−1 and row==row_max−1 → frame_done pulse, IDLE.
- vid_fsync in ACTIVE or DROP: short_frame is set only if in ACTIVE. Counters restart and geometry is re-latched; the next state follows the IDLE rule. The partial line already queued is left without tlast; VDMA resyncs on tuser.
- vid_fsync and vid_valid on the same cycle: the fsync is applied first. That beat is col 0 / row 0 of the new frame (tuser=1) if the new state is ACTIVE.
- vid_valid while the FIFO is full in ACTIVE: the beat is discarded, overflow is set, and the state moves to DROP. DROP discards all beats until vid_fsync.
- Counter widths are 16 bits; geometry arithmetic is done in 17 bits to avoid underflow at col_max=1.
- The FIFO read side is the AXIS master directly. tvalid = !empty. A pop occurs when tvalid && tready. tdata/tuser/tlast are held stable while tvalid && !tready.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - col, row and sticky flags 0.
  - FIFO empty.
- Latency: a beat written in cycle N is visible on m_axis (tvalid=1) in cycle N+1 at the earliest; the FIFO is first-word-fall-through.
- The FIFO accepts a write and a read in the same cycle when full; overflow is judged on the registered full flag before the read.
- frame_done is asserted in the cycle after the final write is registered.
- clear takes effect next cycle. clear and a set event in the same cycle: set wins.
- Reset asserted mid-frame: the FIFO is flushed and all outputs return to 0 asynchronously.

## Configuration
- CTRL_VDMA_IN_STATS_EN defined: adds output ports frame_cnt[31:0] (completed frames) and drop_cnt[31:0] (discarded beats, counting both overflow and DROP state). Both saturate at all-ones and are cleared by clear.
- Undefined: those ports and their counters are absent; all other behaviour is identical.

## Structure
- Package ctrl_vdma_in_pkg:
  - state enum (IDLE, ACTIVE, DROP).
  - FIFO_W = DATA_W+2.
  - Field positions TUSER_BIT=DATA_W, TLAST_BIT=DATA_W+1.
  - Counter width CNT_W=16.
- Sub-module ctrl_vdma_in_fifo: synchronous FWFT FIFO, FIFO_DEPTH×FIFO_W, with full/empty flags and the same clock/reset.

## Test plan
- Geometry 4×3, continuous vid_valid, tready=1 → 12 beats out; tuser on beat 0 only; tlast on beats 3, 7, 11; one frame_done; state back to IDLE.
- Same frame with tready toggling 1/0 every cycle → identical 12-beat sequence; data is held stable during stalls; no overflow.
- FIFO_DEPTH=16, geometry 32×2, tready=0 → 16 beats stored; overflow=1 on beat 17; remaining beats dropped; next fsync starts a clean frame with tuser.
- fsync after 6 beats of a 4×3 frame → short_frame=1; the next beat has tuser=1 with col/row 0.
- fsync with enable=0, or with vdma_column=0 → no output beats; state stays IDLE.
- With CTRL_VDMA_IN_STATS_EN: two complete frames plus one overflow losing 20 beats → frame_cnt=2, drop_cnt=20; clear → both 0.
